dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 29 ++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The FSM state type and the port indices live here so the arbiter and the grant logic agree on them.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_PEND = 1'b1
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a last-grant pointer and a hold input.
// When hold is set, the port named by the pointer wins a conflict and the pointer stays where it is.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_hold,
    output logic [1:0] o_gnt,
    output logic       o_next_last
);

    logic w_pick;

    always_comb begin
        o_gnt       = 2'b00;
        o_next_last = i_last;
        w_pick      = i_hold ? i_last : ~i_last;
        if (i_req == 2'b11) begin
            o_gnt = (w_pick == PORT_DBG) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
        if (!i_hold && (o_gnt != 2'b00)) begin
            o_next_last = o_gnt[PORT_DBG] ? PORT_DBG : PORT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / debug-port arbiter in front of a single-port data memory with one-cycle read latency.
// Optional feature: define DMEM_ARB_LOCK_EN to add dbg_lock, which keeps the debug port in front after it wins.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  cpu_stall_cnt
);

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_next_last;
    logic        w_hold;
    logic        w_rvalid;
    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_owner;
    logic        w_owner_next;
    logic        r_last_gnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Requests are masked during reset so no grant or memory command escapes.
    assign w_req = rst ? {dbg_req, cpu_req} : 2'b00;

`ifdef DMEM_ARB_LOCK_EN
    logic r_lock_armed;

    assign w_hold = dbg_lock & r_lock_armed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lock_armed <= 1'b0;
        end else begin
            r_lock_armed <= dbg_lock & (r_lock_armed | w_gnt[PORT_DBG]);
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req       (w_req),
        .i_last      (r_last_gnt),
        .i_hold      (w_hold),
        .o_gnt       (w_gnt),
        .o_next_last (w_next_last)
    );

    assign cpu_gnt = w_gnt[PORT_CPU];
    assign dbg_gnt = w_gnt[PORT_DBG];

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[PORT_DBG]) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (w_gnt[PORT_CPU]) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // A granted read in either state arms RD_PEND, so back-to-back reads never delay the pending response.
    always_comb begin
        w_state_next = IDLE;
        w_owner_next = r_owner;
        case (r_state)
            IDLE, RD_PEND: begin
                if (mem_en && !mem_we) begin
                    w_state_next = RD_PEND;
                    w_owner_next = w_gnt[PORT_DBG] ? PORT_DBG : PORT_CPU;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_rvalid   = rst && (r_state == RD_PEND);
        cpu_rvalid = w_rvalid && (r_owner == PORT_CPU);
        dbg_rvalid = w_rvalid && (r_owner == PORT_DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= PORT_CPU;
            r_last_gnt  <= PORT_DBG;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_last_gnt <= w_next_last;
            if (cpu_req && !w_gnt[PORT_CPU] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign cpu_stall_cnt = r_stall_cnt;

endmodule
